pc_fetch_unit: RTL and testbench

//  Fetch stage downstream of the next-PC mux. Owns the PCF register, which

---
 rtl/pc_fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns PCF, runs the req/ack instruction-memory handshake and loads IF/ID.
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetch_cycles / perf_killed outputs).
//
// state  | meaning
// S_IDLE | no request outstanding (after reset, or hold buffer full)
// S_REQ  | request outstanding for PCF, response will be used
// S_KILL | request outstanding, response is stale and dropped; PCF then takes pend_q
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_In,
  input  logic        Redirect,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCD,
  output logic [31:0] InstrD,
  output logic        ValidD,
  output logic        FetchBusy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cycles,
  output logic [31:0] perf_killed
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  logic        load_v;
  logic [31:0] load_pc;
  logic [31:0] load_instr;

  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    pend_d       = pend_q;
    hold_full_d  = hold_full_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    load_v       = 1'b0;
    load_pc      = pcf_q;
    load_instr   = imem_rdata;

    case (state_q)
      S_IDLE: begin
        // A redirect makes any buffered word stale, so it is discarded rather than drained.
        if (Redirect) begin
          pcf_d       = PC_In;
          hold_full_d = 1'b0;
        end else if (hold_full_q && !StallD) begin
          load_v      = 1'b1;
          load_pc     = hold_pc_q;
          load_instr  = hold_instr_q;
          hold_full_d = 1'b0;
        end
        state_d = hold_full_d ? S_IDLE : S_REQ;
      end

      S_REQ, S_KILL: begin
        if (imem_ack) begin
          if (Redirect || (state_q == S_KILL)) begin
            // Response dropped; a redirect arriving with the ack wins over the pending target.
            pcf_d   = Redirect ? PC_In : pend_q;
            state_d = S_REQ;
          end else begin
            if (StallD) begin
              hold_full_d  = 1'b1;
              hold_pc_d    = pcf_q;
              hold_instr_d = imem_rdata;
              state_d      = S_IDLE;
            end else begin
              load_v     = 1'b1;
              load_pc    = pcf_q;
              load_instr = imem_rdata;
              state_d    = S_REQ;
            end
            if (!StallF) begin
              pcf_d = PC_In;
            end
          end
        end else if (Redirect) begin
          // Address must stay stable until ack, so the target waits in pend_q.
          pend_d  = PC_In;
          state_d = S_KILL;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pcd_d   = pcd_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (FlushD) begin
      pcd_d   = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!StallD) begin
      if (load_v) begin
        pcd_d   = load_pc;
        instr_d = load_instr;
        valid_d = 1'b1;
      end else begin
        pcd_d   = '0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pcf_q        <= RESET_PC;
      pend_q       <= '0;
      pcd_q        <= '0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      hold_full_q  <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      pend_q       <= pend_d;
      pcd_q        <= pcd_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      hold_full_q  <= hold_full_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;
  assign PCD       = pcd_q;
  assign InstrD    = instr_q;
  assign ValidD    = valid_q;
  assign FetchBusy = ((state_q != S_IDLE) && !imem_ack) || hold_full_q;

`ifdef FETCH_PERF_CNT_EN
  logic        drop;
  logic [31:0] perf_cyc_q, perf_cyc_d;
  logic [31:0] perf_kill_q, perf_kill_d;

  assign drop = (state_q != S_IDLE) && imem_ack && (Redirect || (state_q == S_KILL));

  always_comb begin
    perf_cyc_d  = perf_cyc_q;
    perf_kill_d = perf_kill_q;
    if (imem_req && !imem_ack) begin
      perf_cyc_d = perf_cyc_q + 32'd1;
    end
    if (drop) begin
      perf_kill_d = perf_kill_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cyc_q  <= '0;
      perf_kill_q <= '0;
    end else begin
      perf_cyc_q  <= perf_cyc_d;
      perf_kill_q <= perf_kill_d;
    end
  end

  assign perf_fetch_cycles = perf_cyc_q;
  assign perf_killed       = perf_kill_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios, then random traffic against a queue-based model.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, Redirect, StallF, StallD, FlushD, imem_ack;
  logic [31:0] PC_In, imem_rdata;
  logic        imem_req, ValidD, FetchBusy;
  logic [31:0] imem_addr, PCF, PCD, InstrD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cycles, perf_killed;
`endif

  int ntotal = 0;
  int npass  = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .PC_In(PC_In), .Redirect(Redirect),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .PCF(PCF), .PCD(PCD), .InstrD(InstrD),
    .ValidD(ValidD), .FetchBusy(FetchBusy)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cycles(perf_fetch_cycles), .perf_killed(perf_killed)
`endif
  );

  // Reference model: fetch in flight / squashed flags, a 1-deep queue of held words, IF/ID contents.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        hq[$];
  logic [31:0] m_pcf, m_pcd, m_ins, m_target, m_cyc, m_kil;
  bit          m_vld, m_fetching, m_squash;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(imem_req), 32'(m_fetching));
    chk("imem_addr", imem_addr, m_pcf);
    chk("PCF", PCF, m_pcf);
    chk("PCD", PCD, m_pcd);
    chk("InstrD", InstrD, m_ins);
    chk("ValidD", 32'(ValidD), 32'(m_vld));
    chk("FetchBusy", 32'(FetchBusy), 32'((m_fetching && !imem_ack) || (hq.size() != 0)));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cycles", perf_fetch_cycles, m_cyc);
    chk("perf_killed", perf_killed, m_kil);
`endif
  endtask

  task automatic model_step();
    ent_t        e;
    bit          have;
    logic [31:0] lpc, lins;
    have = 1'b0;
    lpc  = '0;
    lins = '0;
    if (rst) begin
      m_pcf = RESET_PC; m_pcd = '0; m_ins = NOP_INSTR; m_vld = 1'b0;
      m_fetching = 1'b0; m_squash = 1'b0; m_target = '0;
      m_cyc = '0; m_kil = '0;
      hq.delete();
      return;
    end
    if (m_fetching && !imem_ack) m_cyc = m_cyc + 32'd1;
    if (!m_fetching) begin
      if (Redirect) begin
        m_pcf = PC_In;
        hq.delete();
      end else if (hq.size() > 0 && !StallD) begin
        e = hq.pop_front();
        have = 1'b1; lpc = e.pc; lins = e.ins;
      end
      m_fetching = (hq.size() == 0);
    end else if (imem_ack) begin
      if (m_squash || Redirect) begin
        m_kil = m_kil + 32'd1;
        m_pcf = Redirect ? PC_In : m_target;
        m_squash = 1'b0;
      end else begin
        if (StallD) begin
          hq.push_back({m_pcf, imem_rdata});
          m_fetching = 1'b0;
        end else begin
          have = 1'b1; lpc = m_pcf; lins = imem_rdata;
        end
        if (!StallF) m_pcf = PC_In;
      end
    end else if (Redirect) begin
      m_squash = 1'b1;
      m_target = PC_In;
    end
    if (FlushD || (!StallD && !have)) begin
      m_vld = 1'b0; m_ins = NOP_INSTR; m_pcd = '0;
    end else if (!StallD) begin
      m_vld = 1'b1; m_ins = lins; m_pcd = lpc;
    end
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    rst = 1'b0; Redirect = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    PC_In = m_pcf + 32'd4;
  endtask

  initial begin
    m_pcf = RESET_PC;
    quiet_inputs();
    rst = 1'b1;
    model_step();
    @(posedge clk);
    #1;
    tick();
    tick();

    // 1: back-to-back single-cycle acks
    quiet_inputs();
    tick();
    chk("t1_first_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 4; i++) begin
      quiet_inputs();
      imem_ack   = 1'b1;
      imem_rdata = 32'hA000_0000 | m_pcf;
      tick();
    end
    chk("t1_pcf", PCF, 32'd16);
    chk("t1_instr", InstrD, 32'hA000_000C);
    chk("t1_pcd", PCD, 32'd12);
    chk("t1_valid", 32'(ValidD), 32'd1);

    // 2: ack delayed three cycles
    for (int i = 0; i < 3; i++) begin
      quiet_inputs();
      #1;
      chk("t2_addr_stable", imem_addr, 32'd16);
      chk("t2_busy", 32'(FetchBusy), 32'd1);
      tick();
    end
    quiet_inputs();
    imem_ack = 1'b1; imem_rdata = 32'hB000_0010;
    tick();
    chk("t2_instr", InstrD, 32'hB000_0010);
    chk("t2_valid", 32'(ValidD), 32'd1);

    // 3: redirect while request outstanding
    quiet_inputs();
    Redirect = 1'b1; PC_In = 32'h0000_0100;
    tick();
    chk("t3_kill_req", 32'(imem_req), 32'd1);
    chk("t3_kill_addr", imem_addr, 32'd20);
    quiet_inputs();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t3_dropped", 32'(ValidD), 32'd0);
    chk("t3_new_addr", imem_addr, 32'h0000_0100);

    // 4: StallD on ack parks the word in the hold buffer
    quiet_inputs();
    imem_ack = 1'b1; imem_rdata = 32'hC000_0100; StallD = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      quiet_inputs();
      StallD = 1'b1;
      #1;
      chk("t4_no_req", 32'(imem_req), 32'd0);
      chk("t4_busy", 32'(FetchBusy), 32'd1);
      tick();
    end
    quiet_inputs();
    tick();
    chk("t4_drain_instr", InstrD, 32'hC000_0100);
    chk("t4_drain_pcd", PCD, 32'h0000_0100);
    chk("t4_req_resume", 32'(imem_req), 32'd1);

    // 5: FlushD beats StallD
    quiet_inputs();
    imem_ack = 1'b1; imem_rdata = 32'hD000_0104;
    tick();
    quiet_inputs();
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    chk("t5_valid", 32'(ValidD), 32'd0);
    chk("t5_nop", InstrD, NOP_INSTR);

    // 6: reset in KILL, then a stray ack in IDLE
    quiet_inputs();
    Redirect = 1'b1; PC_In = 32'h0000_0200;
    tick();
    quiet_inputs();
    rst = 1'b1;
    tick();
    chk("t6_pcf", PCF, RESET_PC);
    chk("t6_req", 32'(imem_req), 32'd0);
    quiet_inputs();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
    tick();
    chk("t6_stray_valid", 32'(ValidD), 32'd0);
    chk("t6_stray_pcf", PCF, RESET_PC);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      Redirect = ($urandom_range(0, 9) == 0);
      if (Redirect)
        PC_In = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      else
        PC_In = m_pcf + 32'd4;
      StallD = ($urandom_range(0, 3) == 0);
      StallF = StallD ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      FlushD = ($urandom_range(0, 11) == 0);
      imem_ack   = m_fetching ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      imem_rdata = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
